// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronise, debounce and pulse-convert the oven timer's
//             increment/decrement pushbuttons and set/run switch.
//  Option   : BUTTON_AUTO_REPEAT_EN enables auto-repeat while a button is held.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 10000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button1,
    input  logic button2,
    input  logic toggle_set,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_held,
    output logic dec_held,
    output logic run_mode
);

    localparam int unsigned NCH = 3;

    // Bit order: [0]=button1, [1]=button2, [2]=toggle_set.
    localparam logic [NCH-1:0] SYNC_RST = 3'b011;
    localparam logic [NCH-1:0] ACT_LOW  = 3'b011;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam longint unsigned HOLD_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                                           longint'(DEBOUNCE_CYCLES) : longint'(REPEAT_DELAY);
    localparam longint unsigned HOLD_MAX = (HOLD_A > longint'(REPEAT_RATE)) ?
                                           HOLD_A : longint'(REPEAT_RATE);

    if ((CNT_W < 64) && (HOLD_MAX > ((64'd1 << CNT_W) - 64'd1))) begin : g_cnt_w_check
        $error("button_conditioner: CNT_W too narrow for the configured cycle counts");
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
`else
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_PRESS = 1'b1
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Two-flop synchroniser on the raw asynchronous inputs
    // ------------------------------------------------------------------
    logic [NCH-1:0] raw_in;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] level_d;

    assign raw_in = {toggle_set, button2, button1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Debouncers work on active-high "asserted" levels.
    assign level_d = sync2_q ^ ACT_LOW;

    // ------------------------------------------------------------------
    // Debounce: accept a new level after DEBOUNCE_CYCLES mismatching cycles
    // ------------------------------------------------------------------
    logic [NCH-1:0] deb_q;
    logic [NCH-1:0] deb_d;

    for (genvar g = 0; g < NCH; g++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             val_q;
        logic             val_d;

        always_comb begin
            val_d = val_q;
            cnt_d = '0;
            if (level_d[g] != val_q) begin
                if (cnt_q >= DB_LAST) begin
                    val_d = level_d[g];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                val_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                val_q <= val_d;
            end
        end

        assign deb_q[g] = val_q;
        assign deb_d[g] = val_d;
    end

    // Pulses are suppressed while both buttons are down or the oven runs;
    // using next-cycle levels keeps suppression aligned with the *_held edges.
    logic suppress_d;
    assign suppress_d = (deb_d[0] & deb_d[1]) | deb_d[2];

    // ------------------------------------------------------------------
    // Per-button press / auto-repeat FSM with registered pulse output
    // ------------------------------------------------------------------
    logic [1:0] pulse_q;

    for (genvar b = 0; b < 2; b++) begin : g_button_fsm
        state_t state_q;
`ifdef BUTTON_AUTO_REPEAT_EN
        logic [CNT_W-1:0] rcnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= S_IDLE;
                rcnt_q     <= '0;
                pulse_q[b] <= 1'b0;
            end else begin
                pulse_q[b] <= 1'b0;
                if (!deb_d[b]) begin
                    // Release takes priority over any coincident repeat tick.
                    state_q <= S_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            state_q    <= S_PRESS;
                            rcnt_q     <= '0;
                            pulse_q[b] <= ~suppress_d;
                        end
                        S_PRESS: begin
                            if (rcnt_q >= DELAY_LAST) begin
                                state_q    <= S_REPEAT;
                                rcnt_q     <= '0;
                                pulse_q[b] <= ~suppress_d;
                            end else begin
                                rcnt_q <= rcnt_q + CNT_W'(1);
                            end
                        end
                        S_REPEAT: begin
                            if (rcnt_q >= RATE_LAST) begin
                                rcnt_q     <= '0;
                                pulse_q[b] <= ~suppress_d;
                            end else begin
                                rcnt_q <= rcnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end
        end
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= S_IDLE;
                pulse_q[b] <= 1'b0;
            end else begin
                pulse_q[b] <= 1'b0;
                if (!deb_d[b]) begin
                    state_q <= S_IDLE;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            state_q    <= S_PRESS;
                            pulse_q[b] <= ~suppress_d;
                        end
                        S_PRESS: begin
                            state_q <= S_PRESS;
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
`endif
    end

    assign inc_pulse = pulse_q[0];
    assign dec_pulse = pulse_q[1];
    assign inc_held  = deb_q[0];
    assign dec_held  = deb_q[1];
    assign run_mode  = deb_q[2];

endmodule
`default_nettype wire
